// File: rtl/seq_div16_if.sv
// Handshake and result bundle for the seq_div16 multi-cycle divider.
// The control unit is the master and the divider is the slave.
interface seq_div16_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             is_signed;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic             ovfl;

   modport master (
      output start, dividend, divisor, is_signed,
      input  busy, done, quotient, remainder, div_by_zero, ovfl
   );

   modport slave (
      input  start, dividend, divisor, is_signed,
      output busy, done, quotient, remainder, div_by_zero, ovfl
   );
endinterface

// File: rtl/seq_div16.sv
// Restoring shift-subtract divider, one quotient bit per clock, start/busy/done handshake.
// Signed operation is built only when SEQ_DIV_SIGNED_EN is defined; otherwise all operands are unsigned.
module seq_div16 #(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   seq_div16_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rmd_q, rmd_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             negq_q, negq_d, negr_q, negr_d;
   logic             dbz_q, dbz_d, ovf_q, ovf_d;

   logic             sgn;
   logic             dsr_zero;
   logic [WIDTH:0]   sh;
   logic             ge;
   logic             last;

   // With signed support compiled out, sgn is constant 0 and the sign-fix
   // and overflow logic fold away; FIX remains so latency is identical.
`ifdef SEQ_DIV_SIGNED_EN
   assign sgn = bus.is_signed;
`else
   logic unused_sgn;
   assign sgn        = 1'b0;
   assign unused_sgn = bus.is_signed;
`endif

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
      return (s && x[WIDTH-1]) ? -x : x;
   endfunction

   assign dsr_zero = (bus.divisor == '0);
   assign sh       = {rem_q, dvd_q[WIDTH-1]};
   assign ge       = (sh >= {1'b0, dsr_q});
   assign last     = (cnt_q == 5'(WIDTH-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = dsr_zero ? FIX : CALC;
         CALC:    if (last) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy        = (state_q == CALC) || (state_q == FIX);
      bus.done        = (state_q == DONE);
      bus.quotient    = quo_q;
      bus.remainder   = rmd_q;
      bus.div_by_zero = dbz_q;
      bus.ovfl        = ovf_q;
   end

   always_comb begin
      rem_d  = rem_q;
      dvd_d  = dvd_q;
      dsr_d  = dsr_q;
      quo_d  = quo_q;
      rmd_d  = rmd_q;
      cnt_d  = cnt_q;
      negq_d = negq_q;
      negr_d = negr_q;
      dbz_d  = dbz_q;
      ovf_d  = ovf_q;
      case (state_q)
         IDLE: if (bus.start) begin
            // Zero divisor keeps the raw dividend so FIX can return it untouched.
            dvd_d  = dsr_zero ? bus.dividend : mag(bus.dividend, sgn);
            dsr_d  = mag(bus.divisor, sgn);
            rem_d  = '0;
            cnt_d  = '0;
            negq_d = sgn && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            negr_d = sgn && bus.dividend[WIDTH-1];
            dbz_d  = dsr_zero;
            ovf_d  = sgn && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
         end
         CALC: begin
            rem_d = ge ? WIDTH'(sh - {1'b0, dsr_q}) : sh[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], ge};
            cnt_d = cnt_q + 5'd1;
         end
         FIX: begin
            if (dbz_q) begin
               quo_d = '1;
               rmd_d = dvd_q;
            end else begin
               quo_d = negq_q ? -dvd_q : dvd_q;
               rmd_d = negr_q ? -rem_q : rem_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         dvd_q  <= '0;
         dsr_q  <= '0;
         quo_q  <= '0;
         rmd_q  <= '0;
         cnt_q  <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
         dbz_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         dvd_q  <= dvd_d;
         dsr_q  <= dsr_d;
         quo_q  <= quo_d;
         rmd_q  <= rmd_d;
         cnt_q  <= cnt_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
         dbz_q  <= dbz_d;
         ovf_q  <= ovf_d;
      end
   end
endmodule

// File: tb/tb_seq_div16.sv
// Self-checking bench for seq_div16: arithmetic reference model with a per-cycle
// compare, literal directed cases, randomized divides with start noise while busy.
module tb_seq_div16;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   bit   run   = 1'b0;

`ifdef SEQ_DIV_SIGNED_EN
   localparam bit SGN_EN = 1'b1;
`else
   localparam bit SGN_EN = 1'b0;
`endif

   seq_div16_if #(.WIDTH(16)) dif ();
   seq_div16 #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(dif));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic, truncating division.
   function automatic void ref_div(input logic [15:0] a, input logic [15:0] b, input logic sg,
                                   output logic [15:0] q, output logic [15:0] r,
                                   output logic dz, output logic ov);
      int sa, sb;
      dz = 1'b0;
      ov = 1'b0;
      if (b == 16'h0) begin
         q = 16'hFFFF; r = a; dz = 1'b1;
      end else if (sg && SGN_EN) begin
         sa = $signed(a);
         sb = $signed(b);
         if (sa == -32768 && sb == -1) begin
            q = 16'h8000; r = 16'h0; ov = 1'b1;
         end else begin
            q = 16'(sa / sb);
            r = 16'(sa % sb);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Model state: t = cycles since acceptance (0 = idle), len = cycle of done.
   int          t = 0, len = 0;
   logic [15:0] pq, pr, exp_q = '0, exp_r = '0;
   logic        pdz, pov, exp_dz = 1'b0, exp_ov = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t = 0; len = 0; exp_q = '0; exp_r = '0; exp_dz = 1'b0; exp_ov = 1'b0;
      end else if (t == 0) begin
         if (dif.start) begin
            ref_div(dif.dividend, dif.divisor, dif.is_signed, pq, pr, pdz, pov);
            exp_dz = pdz;
            exp_ov = pov;
            len    = pdz ? 2 : 18;
            t      = 1;
         end
      end else if (t == len) begin
         t = 0;
      end else begin
         t++;
         if (t == len) begin
            exp_q = pq;
            exp_r = pr;
         end
      end
   end

   always @(negedge clk) begin
      if (run) begin
         chk("busy", dif.busy, (t != 0) && (t != len));
         chk("done", dif.done, (t != 0) && (t == len));
         if (t == 0 || t == len) begin
            chk("quotient", dif.quotient, exp_q);
            chk("remainder", dif.remainder, exp_r);
            chk("div_by_zero", dif.div_by_zero, exp_dz);
            chk("ovfl", dif.ovfl, exp_ov);
         end else begin
            if (!exp_dz) chk("dbz_cleared", dif.div_by_zero, 1'b0);
            if (!exp_ov) chk("ovfl_cleared", dif.ovfl, 1'b0);
         end
      end
   end

   task automatic do_div(input logic [15:0] a, input logic [15:0] b, input logic sg,
                         input int pulse_at, input bit noise, input bit lit,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edz, input logic eov, input int elat);
      int cyc;
      @(posedge clk); #1;
      dif.start = 1'b1; dif.dividend = a; dif.divisor = b; dif.is_signed = sg;
      @(posedge clk); #1;
      dif.start = 1'b0;
      cyc = 1;
      @(negedge clk);
      while (!dif.done && cyc < 40) begin
         if (cyc == pulse_at) begin
            dif.start = 1'b1; dif.dividend = ~a; dif.divisor = 16'h0003;
         end else if (noise) begin
            dif.start     = 1'($urandom_range(0, 1));
            dif.dividend  = 16'($urandom);
            dif.divisor   = 16'($urandom);
            dif.is_signed = 1'($urandom_range(0, 1));
         end else begin
            dif.start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", dif.done, 1'b1);
      chk("latency", cyc, elat);
      dif.start = (cyc == pulse_at);
      if (lit) begin
         chk("lit_quotient", dif.quotient, eq);
         chk("lit_remainder", dif.remainder, er);
         chk("lit_div_by_zero", dif.div_by_zero, edz);
         chk("lit_ovfl", dif.ovfl, eov);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a, b;
      logic        sg;
      int          cyc;
      rst_n = 1'b0;
      dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0; dif.is_signed = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", dif.busy, 1'b0);
      chk("rst_done", dif.done, 1'b0);
      chk("rst_quotient", dif.quotient, 16'h0);
      chk("rst_remainder", dif.remainder, 16'h0);
      chk("rst_dbz", dif.div_by_zero, 1'b0);
      chk("rst_ovfl", dif.ovfl, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run   = 1'b1;

      do_div(16'h03E8, 16'h0007, 1'b0, -1, 0, 1, 16'h008E, 16'h0006, 0, 0, 18);
      if (SGN_EN) begin
         do_div(16'hFFF9, 16'h0002, 1'b1, -1, 0, 1, 16'hFFFD, 16'hFFFF, 0, 0, 18);
         do_div(16'h8000, 16'hFFFF, 1'b1, -1, 0, 1, 16'h8000, 16'h0000, 0, 1, 18);
      end else begin
         do_div(16'hFFF9, 16'h0002, 1'b1, -1, 0, 1, 16'h7FFC, 16'h0001, 0, 0, 18);
         do_div(16'h8000, 16'hFFFF, 1'b1, -1, 0, 1, 16'h0000, 16'h8000, 0, 0, 18);
      end
      do_div(16'h8000, 16'hFFFF, 1'b0, -1, 0, 1, 16'h0000, 16'h8000, 0, 0, 18);
      do_div(16'h1234, 16'h0000, 1'b0, -1, 0, 1, 16'hFFFF, 16'h1234, 1, 0, 2);
      do_div(16'h0064, 16'h0005, 1'b0, -1, 0, 1, 16'h0014, 16'h0000, 0, 0, 18);
      do_div(16'hFFFF, 16'h0001, 1'b0, 5, 0, 1, 16'hFFFF, 16'h0000, 0, 0, 18);
      do_div(16'h0007, 16'h0002, 1'b0, 18, 0, 1, 16'h0003, 16'h0001, 0, 0, 18);
      do_div(16'h0100, 16'h0010, 1'b0, -1, 0, 1, 16'h0010, 16'h0000, 0, 0, 18);

      // Reset in cycle 8 of a running divide.
      @(posedge clk); #1;
      dif.start = 1'b1; dif.dividend = 16'h03E8; dif.divisor = 16'h0007; dif.is_signed = 1'b0;
      @(posedge clk); #1;
      dif.start = 1'b0;
      cyc = 1;
      @(negedge clk);
      while (cyc < 8) begin
         @(negedge clk);
         cyc++;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", dif.busy, 1'b0);
      chk("midrst_done", dif.done, 1'b0);
      chk("midrst_quotient", dif.quotient, 16'h0);
      chk("midrst_remainder", dif.remainder, 16'h0);
      chk("midrst_dbz", dif.div_by_zero, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("no_done_after_rst", dif.done, 1'b0);
      end
      do_div(16'h03E8, 16'h0007, 1'b0, -1, 0, 1, 16'h008E, 16'h0006, 0, 0, 18);

      for (int n = 0; n < 150; n++) begin
         a  = 16'($urandom);
         sg = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0:       b = 16'h0000;
            1:       begin a = 16'h8000; b = 16'hFFFF; end
            2:       b = 16'h0001;
            3:       b = 16'hFFFF;
            4, 5:    b = 16'($urandom_range(1, 15));
            default: b = 16'($urandom);
         endcase
         do_div(a, b, sg, -1, 1'($urandom_range(0, 1)), 0, '0, '0, 0, 0, (b == 16'h0) ? 2 : 18);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
